dff_pipe: RTL

DFF_PIPE -- requirements
Module: dff_pipe

---
 rtl/dff_pipe_if.sv | 33 +++
 rtl/dff_pipe.sv | 102 ++++++++++
 2 files changed

// File: rtl/dff_pipe_if.sv
// rtl/dff_pipe_if.sv - handshake bundle between a producer/consumer and dff_pipe
// Purpose: groups the upstream, downstream and flush/occupancy signals of dff_pipe.
// Signals:
//   in_valid/in_ready/d     upstream handshake and data
//   out_valid/out_ready/q   downstream handshake and data
//   flush                   discard all pipe contents
//   count                   number of occupied stages
// Modports: master = environment side, slave = pipe side.
interface dff_pipe_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, d, flush, out_ready,
    input  in_ready, out_valid, q, count
  );

  modport slave (
    input  in_valid, d, flush, out_ready,
    output in_ready, out_valid, q, count
  );
endinterface

// File: rtl/dff_pipe.sv
// rtl/dff_pipe.sv - elastic register pipeline with bubble collapse, flush and occupancy count
// Purpose: DEPTH register stages, each with data and valid; words advance whenever the
//          next stage is free, so empty stages never hold back valid words.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active low
//   bus   dff_pipe_if slave modport (in_valid/in_ready/d, out_valid/out_ready/q, flush, count)
module dff_pipe #(
  parameter int               WIDTH   = 4,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic       clk,
  input  logic       rst,
  dff_pipe_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] free;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             in_ready;
  logic             in_fire;

  // A stage is free when it is empty or everything downstream of it moves this cycle.
  // Computed from the output end backwards through a scalar so the chain is not a
  // self-referencing vector.
  always_comb begin
    logic f;
    free = '0;
    f    = !valid_q[DEPTH-1] || bus.out_ready;
    free[DEPTH-1] = f;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      f       = !valid_q[i] || f;
      free[i] = f;
    end
  end

  assign in_ready = free[0] && !bus.flush && rst;
  assign in_fire  = bus.in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end
    count_d = '0;

    // A free stage either drains or was empty, so its new valid is whatever arrives.
    if (free[0]) begin
      valid_d[0] = in_fire;
      if (in_fire) begin
        data_d[0] = bus.d;
      end
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (free[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          data_d[i] = data_q[i-1];
        end
      end
    end

    // Flush drops occupancy only; data registers keep their contents.
    if (bus.flush) begin
      valid_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = data_q[i];
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CW'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RST_VAL;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q[DEPTH-1];
  assign bus.q         = data_q[DEPTH-1];
  assign bus.count     = count_q;
endmodule
